// File: rtl/hazard_controller.sv
// Load-use / RAW hazard and branch-flush control for a 5-stage pipeline.
// A 3-deep scoreboard tracks writers in flight because the register file does not bypass.
module hazard_controller #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        branch_taken,
  output logic        stall_if_id,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic [15:0] hazard_count
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH);

  logic       ex_valid, mw_valid, wb_valid;
  logic [4:0] ex_rd, mw_rd, wb_rd;
  logic [1:0] flush_cnt;

  logic id_effective;
  logic rs1_hit, rs2_hit;
  logic hazard;
  logic ex_load;
  logic branch_accept;

  always_comb begin
    id_effective = id_valid && (flush_cnt == 2'd0);

    rs1_hit = id_uses_rs1 && (id_rs1 != 5'd0) &&
              ((ex_valid && (ex_rd == id_rs1)) ||
               (mw_valid && (mw_rd == id_rs1)) ||
               (wb_valid && (wb_rd == id_rs1)));

    rs2_hit = id_uses_rs2 && (id_rs2 != 5'd0) &&
              ((ex_valid && (ex_rd == id_rs2)) ||
               (mw_valid && (mw_rd == id_rs2)) ||
               (wb_valid && (wb_rd == id_rs2)));

    hazard        = id_effective && (rs1_hit || rs2_hit);
    ex_load       = id_effective && !hazard && id_reg_write && (id_rd != 5'd0);
    branch_accept = id_effective && !hazard && branch_taken;

    stall_if_id  = hazard;
    flush_if_id  = (flush_cnt != 2'd0);
    bubble_id_ex = hazard || flush_if_id;
  end

  // Scoreboard shifts every cycle; a stalled or flushed ID slot enters as invalid.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_valid <= 1'b0;
      mw_valid <= 1'b0;
      wb_valid <= 1'b0;
      ex_rd    <= 5'd0;
      mw_rd    <= 5'd0;
      wb_rd    <= 5'd0;
    end else begin
      wb_valid <= mw_valid;
      wb_rd    <= mw_rd;
      mw_valid <= ex_valid;
      mw_rd    <= ex_rd;
      ex_valid <= ex_load;
      ex_rd    <= ex_load ? id_rd : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      flush_cnt <= 2'd0;
    end else if (branch_accept) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (flush_cnt != 2'd0) begin
      flush_cnt <= flush_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hazard_count <= 16'd0;
    end else if (hazard && (hazard_count != 16'hFFFF)) begin
      hazard_count <= hazard_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: RAW stalls, branch flushes, reset and counter saturation.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_hazard_controller;

  logic        clk;
  logic        resetn;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        id_reg_write;
  logic        branch_taken;
  logic        stall_if_id, bubble_id_ex, flush_if_id;
  logic [15:0] hazard_count;

  int checks;
  int errors;

  hazard_controller #(.FLUSH_DEPTH(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .branch_taken (branch_taken),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .hazard_count (hazard_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID slot and let the combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic br);
    id_valid     = v;
    id_rs1       = rs1;
    id_uses_rs1  = u1;
    id_rs2       = rs2;
    id_uses_rs2  = u2;
    id_rd        = rd;
    id_reg_write = rw;
    branch_taken = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle();
    tick();
    tick();
    resetn = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    // Dirty the state first: a JAL that both flushes and writes, then reset.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    tick();
    resetn = 1'b0;
    idle();
    tick();
    resetn = 1'b1;
    drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_if_id); end
    checks++;
    if (bubble_id_ex !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bubble_id_ex); end
    checks++;
    if (flush_if_id !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_if_id); end
    checks++;
    if (hazard_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", hazard_count); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_stall [0:4];
    exp_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    checks++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL b2b_writer_stall got %b want 0", stall_if_id); end
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      checks++;
      if (stall_if_id !== exp_stall[c][0] || bubble_id_ex !== exp_stall[c][0]) begin
        errors++;
        $display("FAIL b2b_cycle%0d stall/bubble got %b/%b want %b", c, stall_if_id, bubble_id_ex, exp_stall[c][0]);
      end
      tick();
    end
    idle();
    checks++;
    if (hazard_count !== 16'd3) begin errors++; $display("FAIL b2b_count got %0d want 3", hazard_count); end
  endtask

  task automatic test_distance2();
    int stalls;
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      if (stall_if_id === 1'b1) stalls++;
      tick();
    end
    checks++;
    if (stalls != 2) begin errors++; $display("FAIL dist2_stalls got %0d want 2", stalls); end
    idle();
    checks++;
    if (hazard_count !== 16'd2) begin errors++; $display("FAIL dist2_count got %0d want 2", hazard_count); end

    // x0 is never a dependency.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      if (stall_if_id === 1'b1) stalls++;
      tick();
    end
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL x0_stalls got %0d want 0", stalls); end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    // JAL x3: accepted, writes rd.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    checks++;
    if (flush_if_id !== 1'b0 || bubble_id_ex !== 1'b0) begin
      errors++; $display("FAIL br_accept_cycle flush/bubble got %b/%b want 0/0", flush_if_id, bubble_id_ex);
    end
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    checks++;
    if (flush_if_id !== 1'b1 || bubble_id_ex !== 1'b1 || stall_if_id !== 1'b0) begin
      errors++; $display("FAIL br_flush1 flush/bubble/stall got %b/%b/%b want 1/1/0", flush_if_id, bubble_id_ex, stall_if_id);
    end
    tick();
    // A second branch during the flush must not extend it.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    checks++;
    if (flush_if_id !== 1'b1 || bubble_id_ex !== 1'b1) begin
      errors++; $display("FAIL br_flush2 flush/bubble got %b/%b want 1/1", flush_if_id, bubble_id_ex);
    end
    tick();
    // JAL's rd is now in WB: one stall cycle proves it was inserted.
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (flush_if_id !== 1'b0 || stall_if_id !== 1'b1) begin
      errors++; $display("FAIL br_after_flush flush/stall got %b/%b want 0/1", flush_if_id, stall_if_id);
    end
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++;
    if (flush_if_id !== 1'b0 || stall_if_id !== 1'b0 || bubble_id_ex !== 1'b0) begin
      errors++; $display("FAIL br_no_insert flush/stall/bubble got %b/%b/%b want 0/0/0", flush_if_id, stall_if_id, bubble_id_ex);
    end
    tick();
    idle();
  endtask

  task automatic test_blocked_branch();
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    checks++;
    if (stall_if_id !== 1'b1 || flush_if_id !== 1'b0) begin
      errors++; $display("FAIL blk_hazard stall/flush got %b/%b want 1/0", stall_if_id, flush_if_id);
    end
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (stall_if_id !== 1'b1 || flush_if_id !== 1'b0) begin
      errors++; $display("FAIL blk_ignored stall/flush got %b/%b want 1/0", stall_if_id, flush_if_id);
    end
    tick();
    tick();
    checks++;
    if (stall_if_id !== 1'b0 || flush_if_id !== 1'b0) begin
      errors++; $display("FAIL blk_release stall/flush got %b/%b want 0/0", stall_if_id, flush_if_id);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (stall_if_id !== 1'b1) begin errors++; $display("FAIL rms_second_stall got %b want 1", stall_if_id); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (stall_if_id !== 1'b0 || bubble_id_ex !== 1'b0 || flush_if_id !== 1'b0 || hazard_count !== 16'd0) begin
      errors++;
      $display("FAIL rms_cleared stall/bubble/flush/count got %b/%b/%b/%0d want 0/0/0/0",
               stall_if_id, bubble_id_ex, flush_if_id, hazard_count);
    end
    tick();
    checks++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL rms_no_stall got %b want 0", stall_if_id); end
    idle();
  endtask

  task automatic test_saturation();
    int seen;
    int cycles;
    do_reset();
    // Self-dependent writer: re-inserts itself whenever the hazard clears.
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    seen = 0;
    cycles = 0;
    while (seen < 65540 && cycles < 95000) begin
      if (stall_if_id === 1'b1) begin
        seen++;
        tick();
        if (seen == 65534) begin
          checks++;
          if (hazard_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", hazard_count); end
        end
      end else begin
        tick();
      end
      cycles++;
    end
    checks++;
    if (seen != 65540) begin errors++; $display("FAIL sat_timeout stalls got %0d want 65540", seen); end
    checks++;
    if (hazard_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", hazard_count); end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    idle();
    tick();
    tick();
    resetn = 1'b1;
    test_reset();
    test_back_to_back();
    test_distance2();
    test_branch();
    test_blocked_branch();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
